// File: rtl/cpe_pkg.sv
// rtl/cpe_pkg.sv - shared core constants: funct3 access codes, LSU state encoding, LSU timeout default
package cpe_pkg;

  // Load/store access size and sign, taken from the instruction's funct3 field
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bus cycles spent waiting for an ack before the access is aborted
  localparam int LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and lane select plus extension for loads
// Ports:
//   funct3_i     access size/sign
//   addr_lo_i    byte offset within the word
//   we_i         1 = store (unsigned funct3 codes are illegal for stores)
//   wdata_i      raw store data (rs2)
//   bus_rdata_i  word returned by the bus
//   be_o         byte enables for the access
//   wdata_o      store data replicated onto every lane
//   misalign_o   offset not a multiple of the access size
//   illegal_o    funct3 does not name a legal access
//   rdata_o      selected and extended load data
module lsu_align
  import cpe_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    unique case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        misalign_o = |addr_lo_i;
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
      end
      default: illegal_o = 1'b1;
    endcase
    // Stores have no unsigned variants
    if (we_i && funct3_i[2]) illegal_o = 1'b1;
  end

  always_comb begin
    sel_byte = bus_rdata_i[{addr_lo_i, 3'b000} +: 8];
    sel_half = bus_rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    unique case (funct3_i)
      F3_B:    rdata_o = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata_o = {24'h0, sel_byte};
      F3_H:    rdata_o = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata_o = {16'h0, sel_half};
      F3_W:    rdata_o = bus_rdata_i;
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - executes one load or store per request over a req/ack data bus
// Ports:
//   clk_w_i, rst_w_i_h              clock, synchronous active-high reset
//   mem_rd_w_i_h, mem_wr_w_i_h      load/store request from the decoder
//   funct3_w_i, addr_w_i, wdata_w_i access size/sign, byte address, store data
//   rdata_w_o                       extended load result, valid with done
//   stall_w_o_h                     hold pipeline while the access is in flight
//   done_w_o_h, err_w_o_h           completion pulse and coincident fault pulse
//   bus_req/we/addr/be/wdata        bus request side, stable until ack
//   bus_ack_w_i_h, bus_rdata_w_i    bus completion and read word
module load_store_unit
  import cpe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_h,
  input  logic            mem_rd_w_i_h,
  input  logic            mem_wr_w_i_h,
  input  logic [2:0]      funct3_w_i,
  input  logic [XLEN-1:0] addr_w_i,
  input  logic [XLEN-1:0] wdata_w_i,
  output logic [XLEN-1:0] rdata_w_o,
  output logic            stall_w_o_h,
  output logic            done_w_o_h,
  output logic            err_w_o_h,
  output logic            bus_req_w_o_h,
  output logic            bus_we_w_o_h,
  output logic [XLEN-1:0] bus_addr_w_o,
  output logic [3:0]      bus_be_w_o,
  output logic [XLEN-1:0] bus_wdata_w_o,
  input  logic            bus_ack_w_i_h,
  input  logic [XLEN-1:0] bus_rdata_w_i
);

  // Counter value on the last REQ cycle allowed before the abort
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        request;
  logic        in_idle;
  logic        in_req;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic        al_we;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_misalign;
  logic        al_illegal;
  logic [31:0] al_rdata;

  assign request = mem_rd_w_i_h | mem_wr_w_i_h;
  assign in_idle = (state_q == LSU_IDLE);
  assign in_req  = (state_q == LSU_REQ);

  // The aligner checks the live request in IDLE and extends read data
  // against the latched access afterwards.
  assign al_funct3  = in_idle ? funct3_w_i     : f3_q;
  assign al_addr_lo = in_idle ? addr_w_i[1:0]  : addr_q[1:0];
  assign al_we      = in_idle ? mem_wr_w_i_h   : we_q;

  lsu_align u_align (
    .funct3_i    (al_funct3),
    .addr_lo_i   (al_addr_lo),
    .we_i        (al_we),
    .wdata_i     (wdata_w_i),
    .bus_rdata_i (bus_rdata_w_i),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .misalign_o  (al_misalign),
    .illegal_o   (al_illegal),
    .rdata_o     (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (request) begin
          addr_d  = addr_w_i;
          wdata_d = al_wdata;
          be_d    = al_be;
          f3_d    = funct3_w_i;
          we_d    = mem_wr_w_i_h;
          cnt_d   = 8'h0;
          if ((mem_rd_w_i_h && mem_wr_w_i_h) || al_illegal || al_misalign) begin
            // Faulted requests never reach the bus
            state_d = LSU_DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = LSU_REQ;
            err_d   = 1'b0;
          end
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_ack_w_i_h) begin
          state_d = LSU_DONE;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : al_rdata;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      state_q <= LSU_IDLE;
      cnt_q   <= 8'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      f3_q    <= 3'h0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall from IDLE is combinational so the instruction is held on the request cycle
  assign stall_w_o_h   = ~rst_w_i_h & ((in_idle & request) | in_req);
  assign done_w_o_h    = (state_q == LSU_DONE);
  assign err_w_o_h     = done_w_o_h & err_q;
  assign rdata_w_o     = rdata_q;
  assign bus_req_w_o_h = in_req;
  assign bus_we_w_o_h  = in_req & we_q;
  assign bus_addr_w_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be_w_o    = in_req ? be_q : 4'h0;
  assign bus_wdata_w_o = in_req ? wdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a memory model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [logic [31:0]];

  load_store_unit dut (
    .clk_w_i       (clk),
    .rst_w_i_h     (rst),
    .mem_rd_w_i_h  (mem_rd),
    .mem_wr_w_i_h  (mem_wr),
    .funct3_w_i    (funct3),
    .addr_w_i      (addr),
    .wdata_w_i     (wdata),
    .rdata_w_o     (rdata),
    .stall_w_o_h   (stall),
    .done_w_o_h    (done),
    .err_w_o_h     (err),
    .bus_req_w_o_h (bus_req),
    .bus_we_w_o_h  (bus_we),
    .bus_addr_w_o  (bus_addr),
    .bus_be_w_o    (bus_be),
    .bus_wdata_w_o (bus_wdata),
    .bus_ack_w_i_h (bus_ack),
    .bus_rdata_w_i (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa ^ 32'hA5C3_0F1E) * 32'd2654435761;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (wr && f3 > 3'd2) return 1'b1;
    if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if ((a % size_of(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = ((1 << size_of(f3)) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] a);
    int          bits;
    logic [31:0] v, m;
    bits = 8 * size_of(f3);
    v = word >> (8 * (a % 4));
    if (bits >= 32) return v;
    m = (32'h1 << bits) - 32'h1;
    v = v & m;
    if (!f3[2] && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  // One complete access as the pipeline would present it; delay < 0 means never ack
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int delay);
    bit          fault;
    int          cycles;
    logic [31:0] wa, word, lanes, exp_rd;
    logic [3:0]  be;
    fault = is_fault(rd, wr, f3, a);
    wa    = {a[31:2], 2'b00};
    be    = exp_be(f3, a);
    lanes = exp_lanes(f3, wd);
    exp_rd = 32'h0;
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    check("stall_req_cycle", stall, 1);
    check("req_low_first_cycle", bus_req, 0);
    step();
    if (fault) begin
      check("fault_done", done, 1);
      check("fault_err", err, 1);
      check("fault_no_req", bus_req, 0);
      check("fault_stall_low", stall, 0);
    end else begin
      cycles = 0;
      while (bus_req === 1'b1 && cycles < 300) begin
        check("req_stall", stall, 1);
        check("req_addr", bus_addr, wa);
        check("req_be", bus_be, be);
        check("req_we", bus_we, wr);
        if (wr) check("req_wdata", bus_wdata, lanes);
        bus_rdata = $urandom;
        if (cycles == delay) begin
          bus_ack = 1'b1;
          if (!wr) begin
            word = mem_read(wa);
            bus_rdata = word;
            exp_rd = exp_load(word, f3, a);
          end else begin
            word = mem_read(wa);
            for (int i = 0; i < 4; i++)
              if (be[i]) word[8*i +: 8] = lanes[8*i +: 8];
            mem[wa] = word;
          end
        end
        step();
        bus_ack = 1'b0;
        cycles++;
      end
      check("req_cycles", cycles, (delay < 0) ? 255 : delay + 1);
      check("done_pulse", done, 1);
      check("done_err", err, (delay < 0) ? 1 : 0);
      check("done_stall_low", stall, 0);
      check("done_req_low", bus_req, 0);
      check("done_rdata", rdata, exp_rd);
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    step();
    check("back_to_idle_done", done, 0);
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) step();
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;

    // SW, ack on first REQ cycle
    do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0);
    check("sw_mem", mem_read(32'h104), 32'hDEADBEEF);

    // LB / LBU with three wait cycles
    mem[32'h200] = 32'h80FFFFFF;
    do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 3);
    check("lb_value", rdata, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 3);
    check("lbu_value", rdata, 32'h00000080);

    // SH upper half, then misaligned LH
    do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 1);
    do_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0);

    // Illegal store size and both strobes set
    do_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h55, 0);
    do_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h55, 0);

    // LW that is never acked
    do_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, -1);

    // Reset in the middle of REQ, then a late ack
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h300;
    step();
    step();
    check("mid_req_active", bus_req, 1);
    rst = 1'b1; mem_rd = 1'b0;
    step();
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", bus_addr, 0);
    check("mid_rst_be", bus_be, 0);
    check("mid_rst_rdata", rdata, 0);
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    step();
    bus_ack = 1'b0;
    check("late_ack_done", done, 0);
    check("late_ack_req", bus_req, 0);
    check("late_ack_rdata", rdata, 0);
    step();
    check("late_ack_idle", done, 0);

    // Randomized back-to-back traffic over a small window so loads hit earlier stores
    for (int n = 0; n < 60; n++) begin
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) f3 = 3'b010;
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else f3 = (($urandom_range(0, 1) != 0) ? 3'b100 : 3'b000) | 3'($urandom_range(0, 1));
      a = 32'h400 + 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      else if (f3[1:0] != 2'b10) a = a + 32'($urandom_range(0, 3) & ~(size_of(f3) - 1));
      do_access(!wr, wr, f3, a, $urandom, int'($urandom_range(0, 10)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
